// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single WB write port between the ALU
// result path and the load result path. Loads win by default; a saturating
// wait counter force-grants the ALU after MAX_WAIT consecutive lost cycles.
// One registered entry is presented to WB with a valid/ready handshake.
module wb_port_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned TW       = 5,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [DW-1:0] alu_data,
  input  logic [TW-1:0] alu_tag,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic [TW-1:0] ld_tag,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [TW-1:0] wb_tag,
  output logic          wb_src,
  output logic          alu_forced
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WaitMax = CW'(MAX_WAIT);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [DW-1:0] data_q, data_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          src_q, src_d;
  logic          forced_q, forced_d;

  logic can_load, starved, grant_ld, grant_alu;

  // Grant decision; rst_n gating keeps both readies low while reset is held.
  always_comb begin
    can_load  = (state_q == StEmpty) || wb_ready;
    starved   = alu_valid && (wait_q == WaitMax);
    grant_ld  = rst_n && can_load && !flush && ld_valid && !starved;
    grant_alu = rst_n && can_load && !flush && alu_valid && !grant_ld;
  end

  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;

  // Next-state for the entry FSM, the captured entry, wait counter and forced pulse.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    data_d   = data_q;
    tag_d    = tag_q;
    src_d    = src_q;
    forced_d = 1'b0;

    if (flush) begin
      state_d = StEmpty;
    end else if (grant_ld || grant_alu) begin
      state_d = StFull;
    end else if (state_q == StFull && wb_ready) begin
      state_d = StEmpty;
    end

    if (grant_ld) begin
      data_d = ld_data;
      tag_d  = ld_tag;
      src_d  = 1'b1;
    end else if (grant_alu) begin
      data_d = alu_data;
      tag_d  = alu_tag;
      src_d  = 1'b0;
    end

    // Stall (no grant, alu still valid) leaves the counter untouched.
    if (flush || !alu_valid || grant_alu) begin
      wait_d = '0;
    end else if (grant_ld && (wait_q != WaitMax)) begin
      wait_d = wait_q + CW'(1);
    end

    forced_d = grant_alu && ld_valid && (wait_q == WaitMax);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      wait_q   <= '0;
      data_q   <= '0;
      tag_q    <= '0;
      src_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      src_q    <= src_d;
      forced_q <= forced_d;
    end
  end

  assign wb_valid   = (state_q == StFull);
  assign wb_data    = data_q;
  assign wb_tag     = tag_q;
  assign wb_src     = src_q;
  assign alu_forced = forced_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_wb_port_arbiter;

  localparam int DW       = 32;
  localparam int TW       = 5;
  localparam int MAX_WAIT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          alu_valid, alu_ready;
  logic [DW-1:0] alu_data;
  logic [TW-1:0] alu_tag;
  logic          ld_valid, ld_ready;
  logic [DW-1:0] ld_data;
  logic [TW-1:0] ld_tag;
  logic          wb_valid, wb_ready;
  logic [DW-1:0] wb_data;
  logic [TW-1:0] wb_tag;
  logic          wb_src, alu_forced;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one held entry, a lost-cycle count and the forced flag.
  bit            m_valid;
  logic [DW-1:0] m_data;
  logic [TW-1:0] m_tag;
  logic          m_src;
  logic          m_forced;
  int            m_wait;

  wb_port_arbiter #(.DW(DW), .TW(TW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_tag(alu_tag),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_tag(ld_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
    .wb_src(wb_src), .alu_forced(alu_forced)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_valid = 0; m_data = '0; m_tag = '0; m_src = 0; m_forced = 0; m_wait = 0;
  endfunction

  // 0 = none, 1 = ALU, 2 = load
  function automatic int model_grant();
    if (flush || (m_valid && !wb_ready)) return 0;
    if (ld_valid && !(alu_valid && m_wait == MAX_WAIT)) return 2;
    if (alu_valid) return 1;
    return 0;
  endfunction

  function automatic void model_commit(input int g);
    m_forced = (g == 1) && ld_valid && (m_wait == MAX_WAIT);
    if (flush || !alu_valid || g == 1) m_wait = 0;
    else if (g == 2) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
    if (flush) m_valid = 0;
    else if (g == 2) begin m_valid = 1; m_data = ld_data; m_tag = ld_tag; m_src = 1; end
    else if (g == 1) begin m_valid = 1; m_data = alu_data; m_tag = alu_tag; m_src = 0; end
    else if (m_valid && wb_ready) m_valid = 0;
  endfunction

  task automatic drive(input logic f, input logic av, input logic [DW-1:0] ad,
                       input logic [TW-1:0] at, input logic lv, input logic [DW-1:0] ldd,
                       input logic [TW-1:0] lt, input logic wr);
    @(negedge clk);
    flush = f; alu_valid = av; alu_data = ad; alu_tag = at;
    ld_valid = lv; ld_data = ldd; ld_tag = lt; wb_ready = wr;
    #1;
  endtask

  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    #1;
    model_commit(g);
  endtask

  task automatic idle_drain();
    drive(0, 0, '0, '0, 0, '0, '0, 1);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    flush = 0; alu_valid = 1; alu_data = 32'hDEAD; alu_tag = 5'd1;
    ld_valid = 1; ld_data = 32'hBEEF; ld_tag = 5'd2; wb_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", wb_valid); end
    n_cmp++; if (wb_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", wb_data); end
    n_cmp++; if (wb_tag !== '0) begin n_err++; $display("FAIL reset_tag got %h want 0", wb_tag); end
    n_cmp++; if (wb_src !== 1'b0) begin n_err++; $display("FAIL reset_src got %b want 0", wb_src); end
    n_cmp++; if (alu_forced !== 1'b0) begin n_err++; $display("FAIL reset_forced got %b want 0", alu_forced); end
    n_cmp++; if ({alu_ready, ld_ready} !== 2'b00) begin n_err++; $display("FAIL reset_readies got %b want 00", {alu_ready, ld_ready}); end
    @(negedge clk);
    alu_valid = 0; ld_valid = 0;
    rst_n = 1;
  endtask

  task automatic test_alu_only();
    drive(0, 1, 32'h11, 5'd3, 0, '0, '0, 1);
    n_cmp++; if ({alu_ready, ld_ready} !== 2'b10) begin n_err++; $display("FAIL t1_readies got %b want 10", {alu_ready, ld_ready}); end
    tick();
    n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid got %b want 1", wb_valid); end
    n_cmp++; if (wb_data !== 32'h11) begin n_err++; $display("FAIL t1_data got %h want 11", wb_data); end
    n_cmp++; if (wb_tag !== 5'd3) begin n_err++; $display("FAIL t1_tag got %0d want 3", wb_tag); end
    n_cmp++; if (wb_src !== 1'b0) begin n_err++; $display("FAIL t1_src got %b want 0", wb_src); end
    idle_drain();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL t1_drain got %b want 0", wb_valid); end
  endtask

  task automatic test_priority();
    drive(0, 1, 32'h22, 5'd4, 1, 32'hAA, 5'd7, 1);
    n_cmp++; if ({alu_ready, ld_ready} !== 2'b01) begin n_err++; $display("FAIL t2_readies got %b want 01", {alu_ready, ld_ready}); end
    tick();
    n_cmp++; if ({wb_valid, wb_src} !== 2'b11) begin n_err++; $display("FAIL t2_src got %b want 11", {wb_valid, wb_src}); end
    n_cmp++; if (wb_data !== 32'hAA) begin n_err++; $display("FAIL t2_data got %h want aa", wb_data); end
    idle_drain();
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h100 + i, 5'd1, 1, 32'h200 + i, 5'd2, 1);
      n_cmp++;
      if ({alu_ready, ld_ready} !== ((i == 3) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL t3_grant[%0d] got %b want %b", i, {alu_ready, ld_ready}, (i == 3) ? 2'b10 : 2'b01);
      end
      tick();
      n_cmp++;
      if (alu_forced !== (i == 3)) begin
        n_err++; $display("FAIL t3_forced[%0d] got %b want %b", i, alu_forced, (i == 3));
      end
      n_cmp++;
      if (wb_data !== ((i == 3) ? 32'h103 : 32'h200 + i)) begin
        n_err++; $display("FAIL t3_data[%0d] got %h want %h", i, wb_data, (i == 3) ? 32'h103 : 32'h200 + i);
      end
    end
    idle_drain();
    n_cmp++; if (alu_forced !== 1'b0) begin n_err++; $display("FAIL t3_forced_end got %b want 0", alu_forced); end
  endtask

  task automatic test_backpressure();
    drive(0, 0, '0, '0, 1, 32'h55, 5'd9, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, '0, 1, 32'h66, 5'd10, 0);
      n_cmp++; if ({alu_ready, ld_ready} !== 2'b00) begin n_err++; $display("FAIL t4_readies[%0d] got %b want 00", i, {alu_ready, ld_ready}); end
      tick();
      n_cmp++;
      if ({wb_valid, wb_data, wb_tag} !== {1'b1, 32'h55, 5'd9}) begin
        n_err++; $display("FAIL t4_hold[%0d] got %b/%h/%0d want 1/55/9", i, wb_valid, wb_data, wb_tag);
      end
    end
    drive(0, 0, '0, '0, 1, 32'h66, 5'd10, 1);
    n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL t4_release got %b want 1", ld_ready); end
    tick();
    n_cmp++; if (wb_data !== 32'h66) begin n_err++; $display("FAIL t4_new got %h want 66", wb_data); end
    idle_drain();
  endtask

  task automatic test_flush();
    // Three load wins push the lost-cycle count to MAX_WAIT before flushing.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h70, 5'd1, 1, 32'h80 + i, 5'd2, 1);
      tick();
    end
    drive(1, 1, 32'h88, 5'd5, 1, 32'h99, 5'd6, 1);
    n_cmp++; if ({alu_ready, ld_ready} !== 2'b00) begin n_err++; $display("FAIL t5_readies got %b want 00", {alu_ready, ld_ready}); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL t5_valid got %b want 0", wb_valid); end
    n_cmp++; if (wb_data !== 32'h82) begin n_err++; $display("FAIL t5_hold got %h want 82", wb_data); end
    // With the count cleared, the load must win again rather than a forced ALU grant.
    drive(0, 1, 32'h71, 5'd1, 1, 32'h91, 5'd2, 1);
    n_cmp++; if ({alu_ready, ld_ready} !== 2'b01) begin n_err++; $display("FAIL t5_wait_clr got %b want 01", {alu_ready, ld_ready}); end
    tick();
    idle_drain();
  endtask

  task automatic test_async_reset();
    drive(0, 0, '0, '0, 1, 32'hC3, 5'd12, 0);
    tick();
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({wb_valid, wb_data, wb_tag, wb_src, alu_forced} !== '0) begin
      n_err++; $display("FAIL t6_outputs got %b/%h/%0d/%b/%b want all 0", wb_valid, wb_data, wb_tag, wb_src, alu_forced);
    end
    n_cmp++; if ({alu_ready, ld_ready} !== 2'b00) begin n_err++; $display("FAIL t6_readies got %b want 00", {alu_ready, ld_ready}); end
    model_reset();
    @(negedge clk);
    ld_valid = 0;
    rst_n = 1;
    drive(0, 1, 32'h3C, 5'd8, 0, '0, '0, 1);
    tick();
    n_cmp++; if ({wb_valid, wb_data} !== {1'b1, 32'h3C}) begin n_err++; $display("FAIL t6_after got %b/%h want 1/3c", wb_valid, wb_data); end
    idle_drain();
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(7) == 0, $urandom_range(1), $urandom, $urandom,
            $urandom_range(1), $urandom, $urandom, $urandom_range(4) < 3);
      g = model_grant();
      n_cmp++;
      if ({alu_ready, ld_ready} !== {g == 1, g == 2}) begin
        n_err++; $display("FAIL rnd_grant[%0d] got %b want %b", i, {alu_ready, ld_ready}, {g == 1, g == 2});
      end
      tick();
      n_cmp++;
      if ({wb_valid, wb_data, wb_tag, wb_src, alu_forced} !== {m_valid, m_data, m_tag, m_src, m_forced}) begin
        n_err++;
        $display("FAIL rnd_out[%0d] got v%b d%h t%0d s%b f%b want v%b d%h t%0d s%b f%b", i,
                 wb_valid, wb_data, wb_tag, wb_src, alu_forced, m_valid, m_data, m_tag, m_src, m_forced);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_priority();
    test_starvation();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
